// File: rtl/adder_subtractor.sv
// WIDTH-bit two's-complement adder/subtractor built from a ripple chain of full adders.
// Results and status flags are registered with one cycle of latency.
module adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // cin both inverts b and supplies the +1 of the two's-complement negate
    assign bx   = b ^ {WIDTH{cin}};
    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
                ovf  <= c[WIDTH] ^ c[WIDTH-1];
                zero <= ~|s;
            end
        end
    end

endmodule

// File: tb/tb_adder_subtractor.sv
// Randomized and directed checks of adder_subtractor against an integer-arithmetic model.
module tb_adder_subtractor;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;
    localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN  = -(1 << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int exp_sum;
    int exp_cout;
    int exp_ovf;
    int exp_zero;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow
    task automatic model(input int ua, input int ub, input int sub);
        int sa;
        int sb;
        int sres;
        int ures;
        sa = (ua > SMAX) ? ua - MODV : ua;
        sb = (ub > SMAX) ? ub - MODV : ub;
        if (sub != 0) begin
            ures     = ua - ub;
            sres     = sa - sb;
            exp_cout = (ua >= ub) ? 1 : 0;
        end else begin
            ures     = ua + ub;
            sres     = sa + sb;
            exp_cout = (ures >= MODV) ? 1 : 0;
        end
        exp_sum  = ((ures % MODV) + MODV) % MODV;
        exp_ovf  = (sres > SMAX || sres < SMIN) ? 1 : 0;
        exp_zero = (exp_sum == 0) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag, input int valid_exp);
        check({tag, ".valid"}, int'(out_valid), valid_exp);
        check({tag, ".sum"},   int'(sum),       exp_sum);
        check({tag, ".cout"},  int'(cout),      exp_cout);
        check({tag, ".ovf"},   int'(ovf),       exp_ovf);
        check({tag, ".zero"},  int'(zero),      exp_zero);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input int ua, input int ub, input int sub);
        a        = WIDTH'(ua);
        b        = WIDTH'(ub);
        cin      = (sub != 0);
        in_valid = 1'b1;
        model(ua, ub, sub);
        step();
        check_outputs(tag, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        step();
        step();
        exp_sum = 0; exp_cout = 0; exp_ovf = 0; exp_zero = 0;
        check_outputs("reset", 0);
        rst = 1'b0;

        apply("add_5_7",   5, 7, 0);
        check("add_5_7.lit_sum", int'(sum), 12);
        check("add_5_7.lit_ovf", int'(ovf), 1);
        apply("sub_1_2",   1, 2, 1);
        check("sub_1_2.lit_sum", int'(sum), 15);
        check("sub_1_2.lit_cout", int'(cout), 0);
        apply("add_10_1", 10, 1, 0);
        check("add_10_1.lit_sum", int'(sum), 11);
        apply("sub_10_1", 10, 1, 1);
        check("sub_10_1.lit_sum", int'(sum), 9);
        check("sub_10_1.lit_cout", int'(cout), 1);
        apply("add_15_1", 15, 1, 0);
        check("add_15_1.lit_zero", int'(zero), 1);
        apply("sub_0_0",   0, 0, 1);
        check("sub_0_0.lit_cout", int'(cout), 1);
        apply("sub_9_0",   9, 0, 1);
        apply("sub_8_1",   8, 1, 1);
        apply("add_7_1",   7, 1, 0);

        // Idle cycles: flags hold the last result, valid drops
        in_valid = 1'b0;
        a = 4'd3; b = 4'd3; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outputs("idle", 0);
        end

        for (int i = 0; i < 1000; i++) begin
            apply("rand", int'($urandom_range(MODV - 1)), int'($urandom_range(MODV - 1)),
                  int'($urandom_range(1)));
        end

        // Reset wins over a valid input in the same cycle
        a = 4'd5; b = 4'd7; cin = 1'b0; in_valid = 1'b1; rst = 1'b1;
        step();
        exp_sum = 0; exp_cout = 0; exp_ovf = 0; exp_zero = 0;
        check_outputs("rst_valid", 0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_outputs("post_rst", 0);
        apply("after_rst", 12, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
